// File: rtl/kb_divconst_pkg.sv
// Shared types and arithmetic helpers for the kb_divconst sequential divider.
// Used by both the RTL and the testbench.
package kb_divconst_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } kb_state_e;

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
  } kb_dd_pair_t;

  // Width needed for values 0..divisor-1, never less than one bit.
  function automatic int unsigned kb_rem_width(input int unsigned divisor);
    return (divisor <= 2) ? 1 : $clog2(divisor);
  endfunction

  // One long-division step: (r * 2^digit + d) split into quotient and remainder.
  function automatic kb_dd_pair_t kb_digit_divide(input int unsigned r,
                                                  input int unsigned d,
                                                  input int unsigned digit,
                                                  input int unsigned divisor);
    int unsigned num;
    kb_dd_pair_t p;
    num = (r << digit) + d;
    p.q = num / divisor;
    p.r = num % divisor;
    return p;
  endfunction

endpackage

// File: rtl/kb_digit_div.sv
// Combinational digit-divide step: {rem, digit} / DIVISOR via a constant table.
module kb_digit_div
  import kb_divconst_pkg::*;
#(
  parameter  int unsigned DIGIT   = 4,
  parameter  int unsigned DIVISOR = 3,
  localparam int unsigned RW      = kb_rem_width(DIVISOR)
) (
  input  logic [RW-1:0]    i_rem,
  input  logic [DIGIT-1:0] i_digit,
  output logic [DIGIT-1:0] o_quo_c,
  output logic [RW-1:0]    o_rem_c
);

  localparam int unsigned IW      = RW + DIGIT;
  localparam int unsigned ENTRIES = 1 << IW;

  logic [DIGIT-1:0] w_lut_q [ENTRIES];
  logic [RW-1:0]    w_lut_r [ENTRIES];
  logic [IW-1:0]    w_idx;

  // Rows with rem >= DIVISOR are unreachable; their truncated contents are don't-care.
  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_lut
    localparam kb_dd_pair_t P = kb_digit_divide(32'(gi) >> DIGIT,
                                                32'(gi) & ((32'd1 << DIGIT) - 32'd1),
                                                DIGIT, DIVISOR);
    assign w_lut_q[gi] = DIGIT'(P.q);
    assign w_lut_r[gi] = RW'(P.r);
  end

  assign w_idx   = {i_rem, i_digit};
  assign o_quo_c = w_lut_q[w_idx];
  assign o_rem_c = w_lut_r[w_idx];

endmodule

// File: rtl/kb_divconst_seq.sv
// Sequential divide-by-constant, MSB-first, one DIGIT-bit digit per clock.
// Optional round-half-up of the quotient with KB_DIVCONST_ROUND_EN.
module kb_divconst_seq
  import kb_divconst_pkg::*;
#(
  parameter  int unsigned WIDTH   = 20,
  parameter  int unsigned DIGIT   = 4,
  parameter  int unsigned DIVISOR = 3,
  localparam int unsigned RW      = kb_rem_width(DIVISOR)
) (
  input  logic             sys_clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [RW-1:0]    remainder,
  output logic             busy
);

  localparam int unsigned N        = WIDTH / DIGIT;
  localparam int unsigned CW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  if (DIGIT < 1) begin : g_bad_digit
    $fatal(1, "kb_divconst_seq: DIGIT must be at least 1");
  end else if ((WIDTH % DIGIT) != 0) begin : g_bad_width
    $fatal(1, "kb_divconst_seq: WIDTH must be a multiple of DIGIT");
  end
  if (DIVISOR < 2) begin : g_bad_divisor
    $fatal(1, "kb_divconst_seq: DIVISOR must be at least 2");
  end

  kb_state_e        r_state;
  kb_state_e        w_state_nxt;
  logic [WIDTH-1:0] r_shadow;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] w_quot_upd;
  logic [WIDTH-1:0] w_quot_fin;
  logic [CW-1:0]    r_cnt;
  logic [RW-1:0]    r_prem;
  logic [RW-1:0]    r_rem;
  logic [DIGIT-1:0] w_digit;
  logic [DIGIT-1:0] w_q;
  logic [RW-1:0]    w_r;

  assign w_digit = r_shadow[r_cnt*DIGIT +: DIGIT];

  kb_digit_div #(
    .DIGIT   (DIGIT),
    .DIVISOR (DIVISOR)
  ) u_digit_div (
    .i_rem   (r_prem),
    .i_digit (w_digit),
    .o_quo_c (w_q),
    .o_rem_c (w_r)
  );

  // Quotient with the current digit slot replaced by this cycle's lookup result.
  always_comb begin
    w_quot_upd = r_quot;
    w_quot_upd[r_cnt*DIGIT +: DIGIT] = w_q;
  end

`ifdef KB_DIVCONST_ROUND_EN
  logic w_round;
  // Cannot overflow: the floor quotient is at most (2^WIDTH-1)/DIVISOR.
  assign w_round    = ((32'(w_r) << 1) >= DIVISOR);
  assign w_quot_fin = w_quot_upd + WIDTH'(w_round);
`else
  assign w_quot_fin = w_quot_upd;
`endif

  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (in_valid)      w_state_nxt = ST_RUN;
      ST_RUN:  if (r_cnt == '0)   w_state_nxt = ST_DONE;
      ST_DONE: if (out_ready)     w_state_nxt = ST_IDLE;
      default:                    w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: capture in IDLE, one digit per cycle in RUN, hold in DONE.
  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_shadow <= '0;
      r_quot   <= '0;
      r_cnt    <= '0;
      r_prem   <= '0;
      r_rem    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_shadow <= dividend;
            r_prem   <= '0;
            r_cnt    <= CNT_LAST;
          end
        end
        ST_RUN: begin
          r_prem <= w_r;
          r_cnt  <= r_cnt - CW'(1);
          if (r_cnt == '0) begin
            r_quot <= w_quot_fin;
            r_rem  <= w_r;
          end else begin
            r_quot <= w_quot_upd;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign busy      = (r_state == ST_RUN);
  assign out_valid = (r_state == ST_DONE);
  assign quotient  = r_quot;
  assign remainder = r_rem;

endmodule

// File: tb/tb_kb_divconst_seq.sv
// Scoreboard bench for kb_divconst_seq: directed spec cases plus randomized traffic.
module tb_kb_divconst_seq;

  localparam int unsigned TW   = 20;
  localparam int unsigned TDIV = 3;
  localparam int unsigned TN   = 5;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid, in_ready, out_valid, out_ready, busy;
  logic [TW-1:0] dividend, quotient;
  logic [1:0]    remainder;

  logic          in_valid2, in_ready2, out_valid2, busy2;
  logic          out_ready2 = 1'b1;
  logic [19:0]   dividend2, quotient2;
  logic [2:0]    remainder2;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [TW-1:0] q_exp[$];
  logic [1:0]    r_exp[$];
  int            acc_q[$];

  bit force_low  = 1'b0;
  bit rand_bp    = 1'b0;
  bit seen_valid = 1'b0;
  int last_pop_cyc = -100;
  int busy_run     = 0;

  kb_divconst_seq dut (
    .sys_clock (clk),
    .reset_n   (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy)
  );

  kb_divconst_seq #(.WIDTH(20), .DIGIT(2), .DIVISOR(5)) dut5 (
    .sys_clock (clk),
    .reset_n   (rst_n),
    .in_valid  (in_valid2),
    .in_ready  (in_ready2),
    .dividend  (dividend2),
    .out_valid (out_valid2),
    .out_ready (out_ready2),
    .quotient  (quotient2),
    .remainder (remainder2),
    .busy      (busy2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain integer division, optional round-half-up.
  function automatic void model(input logic [TW-1:0] a, output logic [TW-1:0] q,
                                output logic [1:0] r);
    int unsigned ai;
    ai = 32'(a);
    q  = TW'(ai / TDIV);
    r  = 2'(ai % TDIV);
`ifdef KB_DIVCONST_ROUND_EN
    if (2 * (ai % TDIV) >= TDIV) q = q + TW'(1);
`endif
  endfunction

  // Offer a dividend; push the expectation on the accepting edge. Starts/ends at posedge+1.
  task automatic send(input logic [TW-1:0] a, input logic [TW-1:0] q, input logic [1:0] r);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    dividend = a;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (in_ready) begin
        q_exp.push_back(q);
        r_exp.push_back(r);
        acc_q.push_back(cyc);
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got in_ready 0 expected 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    dividend = TW'($urandom);
  endtask

  task automatic send_model(input logic [TW-1:0] a);
    logic [TW-1:0] q;
    logic [1:0]    r;
    model(a, q, r);
    send(a, q, r);
  endtask

  task automatic drain();
    for (int k = 0; k < 500 && q_exp.size() != 0; k++) @(negedge clk);
    if (q_exp.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q_exp.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (force_low)    out_ready = 1'b0;
      else if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
      else              out_ready = 1'b1;
    end
  end

  // Monitor: compare every presented result with the scoreboard head.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_run   = 0;
      seen_valid = 1'b0;
    end else begin
      if (busy) begin
        busy_run++;
        check("in_ready_while_busy", in_ready, 0);
      end else if (busy_run > 0) begin
        check("busy_cycles", busy_run, TN);
        busy_run = 0;
      end
      if (out_valid) begin
        check("in_ready_while_done", in_ready, 0);
        if (q_exp.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output: got quotient %0d with empty scoreboard", quotient);
        end else begin
          check("quotient", quotient, q_exp[0]);
          check("remainder", remainder, r_exp[0]);
          if (!seen_valid) begin
            check("latency", cyc - acc_q[0] - 1, TN);
            seen_valid = 1'b1;
          end
          if (out_ready) begin
            void'(q_exp.pop_front());
            void'(r_exp.pop_front());
            void'(acc_q.pop_front());
            seen_valid   = 1'b0;
            last_pop_cyc = cyc;
          end
        end
      end
    end
  end

  initial begin
    logic [TW-1:0] nq;
    logic [1:0]    nr;
    logic [TW-1:0] nv;
    bit            ok;
    int            c0;

    in_valid = 1'b0; dividend = '0;
    in_valid2 = 1'b0; dividend2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    send(20'd1000000, 20'd333333, 2'd1);
    send(20'hFFFFF, 20'd349525, 2'd0);
    send(20'd0, 20'd0, 2'd0);
`ifdef KB_DIVCONST_ROUND_EN
    send(20'd8, 20'd3, 2'd2);
`else
    send(20'd8, 20'd2, 2'd2);
`endif
    send(20'd7, 20'd2, 2'd1);
    drain();

    // Backpressure: result held with out_ready low while a new dividend waits.
    force_low = 1'b1;
    send_model(20'd123457);
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL bp_wait_valid: got out_valid 0 expected 1");
    end
    @(posedge clk); #1;
    nv = 20'd500001;
    in_valid = 1'b1;
    dividend = nv;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
    end
    force_low = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    check("bp_accept_after_handshake", cyc, last_pop_cyc + 1);
    if (ok) begin
      model(nv, nq, nr);
      q_exp.push_back(nq);
      r_exp.push_back(nr);
      acc_q.push_back(cyc);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();

    // Reset on the third RUN cycle drops the in-flight result.
    send_model(20'd777777);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrun_rst_in_ready", in_ready, 1);
    check("midrun_rst_out_valid", out_valid, 0);
    check("midrun_rst_busy", busy, 0);
    check("midrun_rst_quotient", quotient, 0);
    check("midrun_rst_remainder", remainder, 0);
    q_exp.delete();
    r_exp.delete();
    acc_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(20'd9, 20'd3, 2'd0);
    drain();

    // Randomized traffic with random consumer backpressure.
    rand_bp = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send_model(TW'($urandom));
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end
    rand_bp = 1'b0;
    drain();

    // Second configuration: DIVISOR=5, DIGIT=2.
    in_valid2 = 1'b1;
    dividend2 = 20'd1000003;
    c0 = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (in_ready2) begin c0 = cyc; break; end
    end
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    @(negedge clk);
    check("d5_busy", busy2, 1);
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (out_valid2) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("d5_out_valid", out_valid2, 1);
    check("d5_latency", cyc - c0 - 1, 10);
`ifdef KB_DIVCONST_ROUND_EN
    check("d5_quotient", quotient2, 200001);
`else
    check("d5_quotient", quotient2, 200000);
`endif
    check("d5_remainder", remainder2, 3);
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
